// File: rtl/mac_array_v2.sv
// mac_array_v2: multi-lane signed multiply-accumulate engine.
// Reduces LANES products per beat into one accumulator, one result per group.
module mac_array_v2 #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 4,
    parameter int ELEM_W     = 16,
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 16,
    parameter bit SAT        = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] weight,
    input  logic [CNT_W-1:0]      nbeat,
    input  logic [CNT_W-1:0]      group,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int PW = 2 * ELEM_W + $clog2(LANES);
    localparam int WW = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [DATA_WIDTH-1:0]     r_weight;
    logic [CNT_W-1:0]          r_nbeat;
    logic [CNT_W-1:0]          r_group;
    logic [CNT_W-1:0]          r_beat_cnt;
    logic [CNT_W-1:0]          r_grp_cnt;
    logic signed [2*ELEM_W-1:0] r_prod [LANES];
    logic                      r_pv;
    logic                      r_drn;
    logic                      r_done;
    logic                      r_ovf;
    logic                      r_tlast;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]     r_tdata;

    logic                      w_start_ok;
    logic                      w_accept;
    logic                      w_last_grp;
    logic                      w_last_job;
    logic                      w_more;
    logic                      w_emit_hs;
    logic [CNT_W-1:0]          w_grp_eff;
    logic signed [PW-1:0]      w_sum;
    logic signed [WW-1:0]      w_wide;
    logic signed [ACC_W-1:0]   w_trunc;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic                      w_ovf;

    assign w_start_ok = start && (r_state == S_IDLE);
    assign w_accept   = s_axis_tvalid && s_axis_tready;
    assign w_last_grp = r_grp_cnt == (r_group - CNT_W'(1));
    assign w_last_job = r_beat_cnt == (r_nbeat - CNT_W'(1));
    assign w_more     = r_beat_cnt != r_nbeat;
    assign w_emit_hs  = (r_state == S_EMIT) && m_axis_tready;
    assign w_grp_eff  = (group == '0 || group > nbeat) ? nbeat : group;

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start && nbeat != '0) w_next = S_RUN;
            S_RUN:   if (w_accept && (w_last_grp || w_last_job)) w_next = S_DRAIN;
            S_DRAIN: if (r_drn) w_next = S_EMIT;
            S_EMIT:  if (m_axis_tready) w_next = w_more ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = (r_state == S_RUN);
        m_axis_tvalid = (r_state == S_EMIT);
        busy          = (r_state != S_IDLE);
    end

    assign m_axis_tdata = r_tdata;
    assign m_axis_tlast = r_tlast;
    assign done         = r_done;
    assign overflow     = r_ovf;

    // Stage E0: one registered product per lane
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pv <= 1'b0;
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
        end else begin
            r_pv <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < LANES; i++)
                    r_prod[i] <= $signed(s_axis_tdata[i*ELEM_W +: ELEM_W])
                               * $signed(r_weight[i*ELEM_W +: ELEM_W]);
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) w_sum = w_sum + PW'(r_prod[i]);
    end

    // Extra headroom bit exposes any signed overflow of the ACC_W result
    always_comb begin
        w_wide  = WW'(r_acc) + WW'(w_sum);
        w_trunc = w_wide[ACC_W-1:0];
        w_ovf   = w_wide != WW'(w_trunc);
        if (SAT && w_ovf) w_acc_nxt = w_wide[WW-1] ? ACC_MIN : ACC_MAX;
        else              w_acc_nxt = w_trunc;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_start_ok || w_emit_hs) r_acc <= '0;
            else if (r_pv)               r_acc <= w_acc_nxt;
            if (w_start_ok)          r_ovf <= 1'b0;
            else if (r_pv && w_ovf)  r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_weight   <= '0;
            r_nbeat    <= '0;
            r_group    <= '0;
            r_beat_cnt <= '0;
            r_grp_cnt  <= '0;
            r_drn      <= 1'b0;
            r_done     <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_weight   <= weight;
                r_nbeat    <= nbeat;
                r_group    <= w_grp_eff;
                r_beat_cnt <= '0;
                r_grp_cnt  <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                r_grp_cnt  <= w_last_grp ? '0 : r_grp_cnt + CNT_W'(1);
            end
            r_drn  <= (r_state == S_DRAIN) ? ~r_drn : 1'b0;
            r_done <= (w_start_ok && nbeat == '0) || (w_emit_hs && !w_more);
            if (r_state == S_DRAIN && r_drn) begin
                r_tdata <= DATA_WIDTH'(r_acc);
                r_tlast <= !w_more;
            end
        end
    end
endmodule

// File: tb/tb_mac_array_v2.sv
// tb_mac_array_v2: directed jobs against wrap and saturate instances,
// results checked through a queue-based scoreboard.
module tb_mac_array_v2;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [63:0] weight = '0;
    logic [15:0] nbeat = '0;
    logic [15:0] group = '0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        m_rdy = 1'b1;

    logic        tr0, tv0, tl0, busy0, done0, ov0;
    logic        tr1, tv1, tl1, busy1, done1, ov1;
    logic [63:0] td0, td1;

    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic        eo0, eo1;
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] ALL1 = 64'h0001_0001_0001_0001;

    always #5 clk = ~clk;

    mac_array_v2 #(.SAT(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .weight(weight),
        .nbeat(nbeat), .group(group),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(tr0),
        .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tlast(tl0),
        .m_axis_tready(m_rdy),
        .busy(busy0), .done(done0), .overflow(ov0)
    );

    mac_array_v2 #(.SAT(1'b1)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .weight(weight),
        .nbeat(nbeat), .group(group),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(tr1),
        .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tlast(tl1),
        .m_axis_tready(m_rdy),
        .busy(busy1), .done(done1), .overflow(ov1)
    );

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && tv0 && m_rdy) begin
            if (q0.size() == 0) chk("res0_extra", 72'(q0.size()), 72'd1);
            else chk("res_wrap", {tl0, td0}, q0.pop_front());
        end
        if (rstn && tv1 && m_rdy) begin
            if (q1.size() == 0) chk("res1_extra", 72'(q1.size()), 72'd1);
            else chk("res_sat", {tl1, td1}, q1.pop_front());
        end
    end

    // Reference model: per-group sums with 32-bit wrap and saturation
    task automatic model(input logic [63:0] w, input logic [63:0] d,
                         input int n, input int g);
        int ge, k;
        longint p, a0, a1, s;
        logic signed [15:0] wl, dl;
        logic signed [31:0] t;
        logic [63:0] s64;
        bit last;
        ge = (g == 0 || g > n) ? n : g;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            wl = w[i*16 +: 16];
            dl = d[i*16 +: 16];
            p += longint'(wl) * longint'(dl);
        end
        eo0 = 1'b0; eo1 = 1'b0;
        a0 = 0; a1 = 0; k = 0;
        for (int b = 0; b < n; b++) begin
            s = a0 + p;
            s64 = s;
            t = s64[31:0];
            a0 = longint'(t);
            if (s != a0) eo0 = 1'b1;
            s = a1 + p;
            if (s > 64'sd2147483647) begin
                a1 = 64'sd2147483647; eo1 = 1'b1;
            end else if (s < -64'sd2147483648) begin
                a1 = -64'sd2147483648; eo1 = 1'b1;
            end else a1 = s;
            k++;
            if (k == ge || b == n - 1) begin
                last = (b == n - 1);
                q0.push_back({last, 64'(a0)});
                q1.push_back({last, 64'(a1)});
                a0 = 0; a1 = 0; k = 0;
            end
        end
    endtask

    task automatic do_start(input logic [63:0] w, input int n, input int g);
        @(negedge clk);
        start = 1'b1; weight = w;
        nbeat = 16'(n); group = 16'(g);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [63:0] d, input int n);
        int sent, t;
        sent = 0; t = 0;
        s_tdata = d;
        s_tvalid = 1'b1;
        while (sent < n && t < 400) begin
            if (tr0) sent++;
            if (sent < n) begin
                @(negedge clk);
                t++;
            end
        end
        chk("feed_beats", 72'(sent), 72'(n));
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {done0, done1}, 2'b11);
        chk("busy_at_done", {busy0, busy1}, 2'b00);
        @(negedge clk);
        chk("done_pulse", {done0, done1}, 2'b00);
        chk("queues_drained", 72'(q0.size() + q1.size()), 72'd0);
        chk("overflow", {ov0, ov1}, {eo0, eo1});
    endtask

    task automatic run_job(input logic [63:0] w, input logic [63:0] d,
                           input int n, input int g);
        model(w, d, n, g);
        do_start(w, n, g);
        feed(d, n);
        wait_done();
    endtask

    initial begin
        int t;
        logic [63:0] saved;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs0", {tr0, tv0, tl0, busy0, done0, ov0, td0}, '0);
        chk("reset_outs1", {tr1, tv1, tl1, busy1, done1, ov1, td1}, '0);
        @(negedge clk);
        rstn = 1'b1;

        run_job(ALL1, 64'h0002_0002_0002_0002, 3, 0);
        run_job(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0005, 1, 0);
        run_job(ALL1, ALL1, 5, 2);
        run_job(ALL1, ALL1, 3, 7);
        run_job(64'h0003_FFFE_0003_0003, 64'h7FFF_8000_1234_FFFF, 4, 3);

        // downstream stalls for 10 cycles in EMIT
        m_rdy = 1'b0;
        model(64'h0003_0003_0003_0003, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        do_start(64'h0003_0003_0003_0003, 2, 0);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 2);
        t = 0;
        while (!tv0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("emit_seen", 72'(tv0), 72'd1);
        saved = td0;
        repeat (10) begin
            @(negedge clk);
            chk("emit_hold", {tv0, tr0, td0}, {1'b1, 1'b0, saved});
        end
        @(posedge clk);
        #1 m_rdy = 1'b1;
        wait_done();

        run_job(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 20, 0);
        chk("sat_ovf_set", {ov0, ov1}, 2'b11);

        // reset in the middle of a job
        do_start(ALL1, 5, 0);
        s_tdata = ALL1;
        s_tvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_rst0", {tr0, tv0, tl0, busy0, done0, ov0, td0}, '0);
        chk("midrun_rst1", {tr1, tv1, tl1, busy1, done1, ov1, td1}, '0);
        @(negedge clk);
        rstn = 1'b1;

        model(ALL1, ALL1, 0, 0);
        do_start(ALL1, 0, 0);
        chk("zero_done", {done0, busy0, tv0}, 3'b100);
        @(negedge clk);
        chk("zero_after", {done0, busy0, tv0}, 3'b000);
        chk("zero_ovf", {ov0, ov1}, {eo0, eo1});

        // a start while busy must leave the job untouched
        model(ALL1, ALL1, 2, 0);
        do_start(ALL1, 2, 0);
        chk("busy_running", 72'(busy0), 72'd1);
        @(negedge clk);
        start = 1'b1;
        weight = 64'h0002_0002_0002_0002;
        nbeat = 16'd1;
        @(negedge clk);
        start = 1'b0;
        feed(ALL1, 2);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
